// File: rtl/cache_read_arbiter.sv
// cache_read_arbiter
//   Two-requester AXI read arbiter: icache (s0) and dcache (s1) share one
//   AR/R channel pair toward memory. One transaction is outstanding at a time.
//   The winner's AR fields are latched in IDLE, issued in ADDR, and its R beats
//   are forwarded combinationally in DATA. Arbitration is round-robin.
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   s0_ar*, s1_ar*  : requester read-address channels (valid/ready/addr/id/len/size/burst)
//   s0_r*,  s1_r*   : requester read-data channels (valid/ready/data/resp/last)
//   m_ar*, m_r*     : shared memory-side AR and R channels
//   grant           : index of the requester owning the bus
//   busy            : high when not IDLE
//   len_error       : sticky, a burst's beat count disagreed with its arlen
module cache_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [ID_WIDTH-1:0]   s0_arid,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [ID_WIDTH-1:0]   s1_arid,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  grant,
  output logic                  busy,
  output logic                  len_error
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_req_t;

  state_t  state;
  ar_req_t req_q, s0_req, s1_req;
  logic    grant_q, last_grant, len_err_q, winner, beat_hs;
  logic    act, in_addr, in_data, s0_sel, s1_sel;
  logic [7:0] beat_cnt;

  assign s0_req = {s0_araddr, s0_arid, s0_arlen, s0_arsize, s0_arburst};
  assign s1_req = {s1_araddr, s1_arid, s1_arlen, s1_arsize, s1_arburst};

  // Both valid: the one that did not win last time. Otherwise whoever is valid.
  assign winner  = (s0_arvalid && s1_arvalid) ? ~last_grant : s1_arvalid;
  assign beat_hs = in_data && m_rvalid && m_rready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      req_q      <= '0;
      beat_cnt   <= '0;
      len_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s0_arvalid || s1_arvalid) begin
          grant_q <= winner;
          req_q   <= winner ? s1_req : s0_req;
          state   <= ADDR;
        end
        ADDR: if (m_arready) begin
          beat_cnt <= '0;
          state    <= DATA;
        end
        DATA: if (beat_hs) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (m_rlast) begin
            if (beat_cnt != req_q.len) len_err_q <= 1'b1;
            last_grant <= grant_q;
            state      <= IDLE;
          end else if (beat_cnt == req_q.len) begin
            // Expected final beat without rlast: flag it, keep forwarding.
            len_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is forced low while reset is held, even on the first
  // reset cycle before the state register has been cleared.
  assign act     = ~reset;
  assign in_addr = act && (state == ADDR);
  assign in_data = act && (state == DATA);
  assign s0_sel  = in_data && !grant_q;
  assign s1_sel  = in_data &&  grant_q;

  assign m_arvalid = in_addr;
  assign m_araddr  = in_addr ? req_q.addr  : '0;
  assign m_arid    = in_addr ? req_q.id    : '0;
  assign m_arlen   = in_addr ? req_q.len   : '0;
  assign m_arsize  = in_addr ? req_q.size  : '0;
  assign m_arburst = in_addr ? req_q.burst : '0;

  assign s0_arready = in_addr && !grant_q && m_arready;
  assign s1_arready = in_addr &&  grant_q && m_arready;

  assign m_rready  = (s0_sel && s0_rready) || (s1_sel && s1_rready);
  assign s0_rvalid = s0_sel && m_rvalid;
  assign s1_rvalid = s1_sel && m_rvalid;
  assign s0_rdata  = s0_sel ? m_rdata : '0;
  assign s1_rdata  = s1_sel ? m_rdata : '0;
  assign s0_rresp  = s0_sel ? m_rresp : '0;
  assign s1_rresp  = s1_sel ? m_rresp : '0;
  assign s0_rlast  = s0_sel && m_rlast;
  assign s1_rlast  = s1_sel && m_rlast;

  assign grant     = act && grant_q;
  assign busy      = act && (state != IDLE);
  assign len_error = act && len_err_q;
endmodule

// File: tb/tb_cache_read_arbiter.sv
module tb_cache_read_arbiter;
  localparam int IW = 13, AW = 64, DW = 64;
  localparam logic [AW-1:0] A0 = 64'h0000_1000, A1 = 64'h0000_2000;
  localparam logic [IW-1:0] ID0 = 13'd5, ID1 = 13'd9;

  logic clk = 1'b0, reset;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [AW-1:0] s0_araddr, s1_araddr, m_araddr;
  logic [IW-1:0] s0_arid, s1_arid, m_arid;
  logic [7:0] s0_arlen, s1_arlen, m_arlen;
  logic [2:0] s0_arsize, s1_arsize, m_arsize;
  logic [1:0] s0_arburst, s1_arburst, m_arburst, s0_rresp, s1_rresp, m_rresp;
  logic [DW-1:0] s0_rdata, s1_rdata, m_rdata;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic grant, busy, len_error;

  cache_read_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arid(s0_arid), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arid(s1_arid), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .grant(grant), .busy(busy), .len_error(len_error)
  );

  always #5 clk = ~clk;

  // in  = {reset, s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready}
  // exp = {m_arvalid, s0_arready, s1_arready, m_rready, s0_rvalid, s1_rvalid, grant, busy, len_error}
  typedef struct {
    logic [7:0]    in;
    logic [8:0]    exp;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t vq[$];
  int checks = 0, failures = 0;

  function automatic vec_t mk(logic [7:0] in, logic [8:0] exp, logic [AW-1:0] addr);
    vec_t v;
    v.in = in; v.exp = exp; v.addr = addr;
    return v;
  endfunction

  function automatic logic [8:0] flags();
    return {m_arvalid, s0_arready, s1_arready, m_rready, s0_rvalid, s1_rvalid,
            grant, busy, len_error};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int beat, cyc;
    reset = 1'b1;
    {s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready} = '0;
    s0_araddr = A0; s0_arid = ID0; s0_arlen = 8'd7; s0_arsize = 3'd3; s0_arburst = 2'd1;
    s1_araddr = A1; s1_arid = ID1; s1_arlen = 8'd7; s1_arsize = 3'd3; s1_arburst = 2'd1;
    m_rdata = '0; m_rresp = 2'd0;

    // Reset, simultaneous request (s0 wins), full s0 burst with s1 waiting,
    // then simultaneous request again (s1 wins).
    vq.push_back(mk(8'b1000_0000, 9'b000000000, '0));
    vq.push_back(mk(8'b1000_0000, 9'b000000000, '0));
    vq.push_back(mk(8'b0110_0000, 9'b000000000, '0));
    vq.push_back(mk(8'b0111_0000, 9'b110000010, A0));
    for (int i = 0; i < 7; i++) vq.push_back(mk(8'b0011_1010, 9'b000110010, '0));
    vq.push_back(mk(8'b0011_1110, 9'b000110010, '0));
    vq.push_back(mk(8'b0110_0000, 9'b000000000, '0));
    vq.push_back(mk(8'b0111_0000, 9'b101000110, A1));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      {reset, s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready} = vq[i].in;
      #1;
      chk($sformatf("vec[%0d]", i), {flags(), m_araddr}, {vq[i].exp, vq[i].addr});
    end

    // s1 burst with 3 stall cycles; s0 keeps requesting and must wait.
    beat = 0; cyc = 0;
    while (beat < 8 && cyc < 40) begin
      @(negedge clk);
      s0_arvalid = 1'b1; s1_arvalid = 1'b0; m_arready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 64'hD000 + 64'(beat); m_rlast = (beat == 7);
      s1_rready = !(cyc >= 3 && cyc <= 5);
      #1;
      chk("stall_ctl", {s0_rvalid, s1_rvalid, m_rready, s0_arready}, {1'b0, 1'b1, s1_rready, 1'b0});
      if (s1_rready) begin
        chk("stall_data", {s1_rdata, s1_rlast}, {64'hD000 + 64'(beat), beat == 7});
        beat++;
      end
      cyc++;
    end
    chk("stall_beats", 128'(beat), 128'd8);
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; #1;
    chk("after_s1", {busy, len_error, grant}, 3'b001);

    // s0 burst with arlen=7 but rlast on beat 6.
    @(negedge clk);
    m_arready = 1'b1; #1;
    chk("short_addr", {s0_arready, grant, m_araddr}, {1'b1, 1'b0, A0});
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      s0_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1; s0_rready = 1'b1;
      m_rlast = (b == 5); #1;
      chk("short_beat", {s0_rvalid, m_rready}, 2'b11);
    end
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; s1_arvalid = 1'b1; #1;
    chk("short_err", {len_error, busy}, 2'b10);

    // s1 request with m_arready low 5 cycles; s1 drops arvalid and changes addr.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin s1_arvalid = 1'b0; s1_araddr = 64'hDEAD_BEEF; end
      #1;
      chk("ar_hold", {m_arvalid, s0_arready, s1_arready, grant, m_araddr, m_arid, m_arlen},
          {1'b1, 1'b0, 1'b0, 1'b1, A1, ID1, 8'd7});
    end
    @(negedge clk);
    m_arready = 1'b1; #1;
    chk("ar_accept", {m_arvalid, s1_arready, m_araddr}, {1'b1, 1'b1, A1});
    s1_araddr = A1;

    // Three beats, then reset during beat 4.
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      m_arready = 1'b0; m_rvalid = 1'b1; s1_rready = 1'b1; #1;
      chk("pre_rst_beat", {s1_rvalid, len_error}, 2'b11);
    end
    @(negedge clk);
    reset = 1'b1; #1;
    chk("in_reset", {flags(), s1_rdata}, {9'b0, 64'h0});
    @(negedge clk);
    reset = 1'b0; #1;
    chk("post_reset", {flags(), m_araddr}, {9'b0, 64'h0});

    // After reset last_grant is 1, so s0 wins a simultaneous request.
    @(negedge clk);
    m_rvalid = 1'b0; s0_arvalid = 1'b1; s1_arvalid = 1'b1; #1;
    chk("rearb_idle", 128'(flags()), 128'(9'b0));
    @(negedge clk);
    m_arready = 1'b1; #1;
    chk("rearb_addr", {flags(), m_araddr}, {9'b110000010, A0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_read_arbiter.md
CACHE_READ_ARBITER -- requirements
Module: cache_read_arbiter

Interface
REQ-001 Parameters: ID_WIDTH, default 13, AXI transaction ID width; ADDR_WIDTH, default 64, address width; DATA_WIDTH, default 64, read data width.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Notation: each sN_ line defines one port per requester, s0_ (icache) and s1_ (dcache).
REQ-005 sN_arvalid  input  1  read request valid.
REQ-006 sN_arready  output  1  read request accepted.
REQ-007 sN_araddr  input  ADDR_WIDTH  request address.
REQ-008 sN_arid  input  ID_WIDTH  request ID.
REQ-009 sN_arlen  input  8  burst length minus one.
REQ-010 sN_arsize  input  3  beat size, log2 bytes.
REQ-011 sN_arburst  input  2  burst type.
REQ-012 sN_rvalid  output  1  read beat valid.
REQ-013 sN_rready  input  1  read beat accepted.
REQ-014 sN_rdata  output  DATA_WIDTH  read beat data.
REQ-015 sN_rresp  output  2  read beat response.
REQ-016 sN_rlast  output  1  final beat of burst.
REQ-017 m_arvalid  output  1; m_arready  input  1; m_araddr  output  ADDR_WIDTH; m_arid  output  ID_WIDTH; m_arlen  output  8; m_arsize  output  3; m_arburst  output  2: shared AR channel.
REQ-018 m_rvalid  input  1; m_rready  output  1; m_rdata  input  DATA_WIDTH; m_rresp  input  2; m_rlast  input  1: shared R channel.
REQ-019 grant  output  1  index of the requester currently owning the bus.
REQ-020 busy  output  1  high whenever state is not IDLE.
REQ-021 len_error  output  1  sticky flag: burst beat count mismatched its latched arlen.

Function
REQ-022 The block SHALL implement three states, IDLE, ADDR and DATA, with one transaction outstanding at a time.
REQ-023 IDLE: if any sN_arvalid is high, the block SHALL select a winner, latch that requester's araddr/arid/arlen/arsize/arburst, set grant to the winner and go to ADDR next cycle; otherwise it stays in IDLE.
REQ-024 Arbitration SHALL be round-robin: with both requesters valid, the requester not equal to last_grant wins; with one requester valid, that requester wins.
REQ-025 ADDR: m_arvalid=1 and m_ar* SHALL come from the latched registers; s[grant]_arready SHALL equal m_arready, and the other sN_arready SHALL be 0.
REQ-026 On the ADDR cycle with m_arready=1, the block SHALL clear the beat counter and go to DATA.
REQ-027 Latency from sN_arvalid rising in IDLE to m_arvalid SHALL be exactly 1 cycle.
REQ-028 DATA: s[grant]_rvalid=m_rvalid, m_rready=s[grant]_rready, and rdata/rresp/rlast SHALL pass through combinationally with zero latency; the non-granted requester's rvalid SHALL be 0.
REQ-029 Each beat handshake (m_rvalid and m_rready) SHALL increment an 8-bit beat counter.
REQ-030 On a beat handshake with m_rlast=1, the block SHALL set last_grant to grant and return to IDLE; a new arbitration is possible on the following cycle.
REQ-031 len_error SHALL be set, and hold until reset, when either: the rlast beat has counter != latched arlen; or a beat with counter == arlen arrives without rlast. In the second case the block SHALL keep forwarding beats until rlast.
REQ-032 arready, m_arvalid and m_rready SHALL be 0 in every state except the one where each is defined above.
REQ-033 Deassertion of the granted sN_arvalid during ADDR SHALL be ignored; the latched request is still issued.
REQ-034 A request from the non-granted requester during ADDR or DATA SHALL wait without being acknowledged; it is arbitrated in the next IDLE.

Reset
REQ-035 On reset the block SHALL enter IDLE, clear the latched request registers, the beat counter and len_error, and set grant=0 and last_grant=1.
REQ-036 During reset all outputs SHALL be 0.
REQ-037 Reset mid-transaction SHALL abandon the burst with no drain; the first cycle after reset is IDLE.

Verification
REQ-038 Reset, then s0 and s1 both assert arvalid in the same cycle -> s0 wins: m_arvalid next cycle, m_araddr=s0_araddr, grant=0.
REQ-039 s0 request completes (arlen=7, 8 beats, rlast on beat 8), then both requesters valid again -> s1 wins; len_error stays 0.
REQ-040 s1 burst with s1_rready low for 3 cycles mid-burst -> m_rready low for those cycles, no beat lost, 8 beats delivered in order, s0_rvalid=0 throughout.
REQ-041 arlen=7 but m_rlast on beat 6 -> len_error=1, state returns to IDLE; next transaction arbitrates normally.
REQ-042 reset asserted during beat 4 of a burst -> next cycle busy=0, all outputs 0, len_error=0.
REQ-043 m_arready held low 5 cycles in ADDR -> m_arvalid and the latched fields stay stable; sN_arready pulses only on the accept cycle.
